gerador_paridade_serial: RTL

- Transmit end of the parity path: accepts a DATA_W-bit data word, appends a parity bit, and shifts the frame out serially as start, data LSB-first, parity, stop.
- Also presents the encoded (DATA_W+1)-bit word in parallel, in the exact format the parity verifier consumes.
- Feeds the parity-check/7-segment display path and serial link tests.

---
 rtl/gerador_paridade_serial.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/gerador_paridade_serial.sv
// gerador_paridade_serial: serial parity-frame transmitter.
// Accepts a DATA_W-bit word and appends its parity bit.
// Sends start, data LSB-first, parity, stop on saida_serial.
// The encoded word also appears in parallel on palavra.
// Ports:
//   clk, rst_n     - clock (rising) / async active-low reset
//   dado, valido   - word to send / request (accept when pronto)
//   pronto         - idle, ready to accept
//   ocupado        - frame in progress (~pronto)
//   saida_serial   - serial line, idles high
//   palavra        - {dado, parity}, held until next accept
//   palavra_valida - one-cycle pulse after accept
// Optional macro GERADOR_INJETA_ERRO_EN adds input forca_erro;
// when high at accept, that frame carries an inverted parity bit.
module gerador_paridade_serial #(
    parameter int DATA_W       = 5,
    parameter bit ODD_PARITY   = 1'b0,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dado,
    input  logic              valido,
`ifdef GERADOR_INJETA_ERRO_EN
    input  logic              forca_erro,
`endif
    output logic              pronto,
    output logic              ocupado,
    output logic              saida_serial,
    output logic [DATA_W:0]   palavra,
    output logic              palavra_valida
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] ULTIMO_BIT = BW'(DATA_W - 1);
    localparam logic [7:0]    ULTIMO_CLK = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

    estado_t           estado;
    logic [DATA_W-1:0] shift;
    logic              par;
    logic [7:0]        baud;
    logic [BW-1:0]     bit_cnt;
    logic              erro;
    logic              aceite;
    logic              fim_bit;
    logic              par_novo;

`ifdef GERADOR_INJETA_ERRO_EN
    assign erro = forca_erro;
`else
    assign erro = 1'b0;
`endif

    assign pronto   = (estado == OCIOSO);
    assign ocupado  = ~pronto;
    assign aceite   = valido & pronto;
    assign fim_bit  = (baud == ULTIMO_CLK);
    assign par_novo = (^dado) ^ ODD_PARITY ^ erro;

    // saida_serial is loaded from the current state's line level,
    // so the line trails the state by one clock: the start bit
    // shows up on the edge after the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            shift          <= '0;
            par            <= 1'b0;
            baud           <= '0;
            bit_cnt        <= '0;
            saida_serial   <= 1'b1;
            palavra        <= '0;
            palavra_valida <= 1'b0;
        end else begin
            palavra_valida <= aceite;
            case (estado)
                OCIOSO: begin
                    saida_serial <= 1'b1;
                    baud         <= '0;
                    bit_cnt      <= '0;
                    if (aceite) begin
                        shift   <= dado;
                        par     <= par_novo;
                        palavra <= {dado, par_novo};
                        estado  <= INICIO;
                    end
                end
                INICIO: begin
                    saida_serial <= 1'b0;
                    if (fim_bit) begin
                        baud   <= '0;
                        estado <= DADOS;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                DADOS: begin
                    saida_serial <= shift[0];
                    if (fim_bit) begin
                        baud  <= '0;
                        shift <= shift >> 1;
                        if (bit_cnt == ULTIMO_BIT) begin
                            bit_cnt <= '0;
                            estado  <= PARIDADE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                PARIDADE: begin
                    saida_serial <= par;
                    if (fim_bit) begin
                        baud   <= '0;
                        estado <= PARADA;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                PARADA: begin
                    saida_serial <= 1'b1;
                    if (fim_bit) begin
                        baud   <= '0;
                        estado <= OCIOSO;
                    end else begin
                        baud <= baud + 8'd1;
                    end
                end
                default: begin
                    saida_serial <= 1'b1;
                    baud         <= '0;
                    estado       <= OCIOSO;
                end
            endcase
        end
    end

endmodule
